// File: rtl/flag_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | flag_pkg: stream length, FSM state encoding, expected byte table |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package flag_pkg;

  localparam int LEN = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [7:0] TARGET [0:31] = '{
    8'd182, 8'd45,  8'd201, 8'd17,  8'd99,  8'd6,   8'd240, 8'd73,
    8'd128, 8'd55,  8'd3,   8'd190, 8'd87,  8'd222, 8'd31,  8'd160,
    8'd74,  8'd12,  8'd255, 8'd101, 8'd66,  8'd139, 8'd8,   8'd177,
    8'd250, 8'd43,  8'd119, 8'd200, 8'd91,  8'd14,  8'd163, 8'd215
  };

endpackage
`default_nettype wire

// File: rtl/flag_target_rom.sv
`default_nettype none
// +------------------------------------------------------------------+
// | flag_target_rom: combinational index -> expected byte lookup     |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module flag_target_rom
  import flag_pkg::*;
(
  input  logic [5:0] idx,
  output logic [7:0] data
);

  // Indices beyond the 32-entry table read as zero.
  always_comb begin
    data = 8'h00;
    if (!idx[5]) data = TARGET[idx[4:0]];
  end

endmodule
`default_nettype wire

// File: rtl/flag_verdict.sv
`default_nettype none
// +------------------------------------------------------------------+
// | flag_verdict: compares a byte stream to the target table, reports|
// | pass/timeout verdict, first mismatch index and mismatch count    |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module flag_verdict #(
  parameter int LEN     = flag_pkg::LEN,
  parameter int TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic       timeout,
  output logic [5:0] err_idx,
  output logic [5:0] err_cnt
);

  localparam int         IDLE_W   = $clog2(TIMEOUT + 1);
  localparam logic [5:0] LEN_IDX  = 6'(LEN);
  localparam logic [5:0] LAST_IDX = 6'(LEN - 1);

  logic [1:0]        state_q,   state_d;
  logic [5:0]        idx_q,     idx_d;
  logic [IDLE_W-1:0] idle_q,    idle_d;
  logic [5:0]        err_cnt_q, err_cnt_d;
  logic [5:0]        err_idx_q, err_idx_d;
  logic              pass_q,    pass_d;
  logic              timeout_q, timeout_d;
  logic [7:0]        rom_data;

  flag_target_rom u_rom (
    .idx  (idx_q),
    .data (rom_data)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    idle_d    = idle_q;
    err_cnt_d = err_cnt_q;
    err_idx_d = err_idx_q;
    pass_d    = pass_q;
    timeout_d = timeout_q;
    case (state_q)
      flag_pkg::ST_IDLE, flag_pkg::ST_RUN: begin
        // start (re)arms from IDLE or RUN; a byte in the same cycle is dropped
        if (start) begin
          state_d   = flag_pkg::ST_RUN;
          idx_d     = '0;
          idle_d    = '0;
          err_cnt_d = '0;
          err_idx_d = LEN_IDX;
          pass_d    = 1'b0;
          timeout_d = 1'b0;
        end else if (state_q == flag_pkg::ST_RUN) begin
          if (in_valid) begin
            idle_d = '0;
            if (in_data != rom_data) begin
              err_cnt_d = err_cnt_q + 6'd1;
              if (err_idx_q == LEN_IDX) err_idx_d = idx_q;
            end
            if (idx_q == LAST_IDX) begin
              state_d = flag_pkg::ST_DONE;
              pass_d  = (err_cnt_d == 6'd0);
            end else begin
              idx_d = idx_q + 6'd1;
            end
          end else begin
            idle_d = idle_q + 1'b1;
            if (idle_d == IDLE_W'(TIMEOUT)) begin
              state_d   = flag_pkg::ST_DONE;
              timeout_d = 1'b1;
              pass_d    = 1'b0;
            end
          end
        end
      end
      flag_pkg::ST_DONE: state_d = flag_pkg::ST_IDLE;
      default:           state_d = flag_pkg::ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= flag_pkg::ST_IDLE;
      idx_q     <= '0;
      idle_q    <= '0;
      err_cnt_q <= '0;
      err_idx_q <= LEN_IDX;
      pass_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      idle_q    <= idle_d;
      err_cnt_q <= err_cnt_d;
      err_idx_q <= err_idx_d;
      pass_q    <= pass_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy    = (state_q == flag_pkg::ST_RUN);
  assign done    = (state_q == flag_pkg::ST_DONE);
  assign pass    = pass_q;
  assign timeout = timeout_q;
  assign err_idx = err_idx_q;
  assign err_cnt = err_cnt_q;

endmodule
`default_nettype wire
